// File: rtl/frame_rx_pkg.sv
// Shared defaults and helpers for the receive-side CRC-8 checker.
// Defaults correspond to CRC-8/ATM: poly 07, init 00, no reflection, no output XOR.
package frame_rx_pkg;

    localparam int          DATA_W_DEF  = 8;
    localparam int          CRC_W_DEF   = 8;
    localparam logic [7:0]  POLY_DEF    = 8'h07;
    localparam logic [7:0]  INIT_DEF    = 8'h00;
    localparam logic [7:0]  XOR_OUT_DEF = 8'h00;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc8_step.sv
// Combinational CRC update over DATA_W input bits, MSB first, one LFSR step per bit.
module crc8_step #(
    parameter int CRC_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CRC_W-1:0]  poly,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] crc_s;
    logic             fb_s;

    // Unrolled serial LFSR: feedback is the outgoing CRC MSB xor the data bit.
    always_comb begin
        crc_s = crc_in;
        fb_s  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb_s  = crc_s[CRC_W-1] ^ data_in[i];
            crc_s = {crc_s[CRC_W-2:0], 1'b0} ^ (fb_s ? poly : {CRC_W{1'b0}});
        end
        crc_out = crc_s;
    end

endmodule

// File: rtl/frame_receiver.sv
// Streaming CRC checker: accumulates a CRC over every byte since reset and flags,
// one cycle later, whether the finalised CRC matched the crc_received byte.
module frame_receiver
    import frame_rx_pkg::*;
#(
    parameter int               DATA_W  = DATA_W_DEF,
    parameter int               CRC_W   = CRC_W_DEF,
    parameter logic [CRC_W-1:0] POLY    = POLY_DEF,
    parameter logic [CRC_W-1:0] INIT    = INIT_DEF,
    parameter bit               REF_IN  = 1'b0,
    parameter bit               REF_OUT = 1'b0,
    parameter logic [CRC_W-1:0] XOR_OUT = XOR_OUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] frame_data,
    input  logic [CRC_W-1:0]  crc_received,
    output logic              crc_valid
);

    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  crc_d;
    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_s;
    logic [CRC_W-1:0]  crc_next_s;
    logic [CRC_W-1:0]  fin_s;

    // Input reflection is applied per byte, so wide data words keep byte order.
    always_comb begin
        data_s = frame_data;
        for (int k = 0; k < DATA_W / 8; k++) begin
            if (REF_IN) begin
                data_s[k*8 +: 8] = bitrev8(frame_data[k*8 +: 8]);
            end else begin
                data_s[k*8 +: 8] = frame_data[k*8 +: 8];
            end
        end
    end

    crc8_step #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W)
    ) u_step (
        .crc_in  (crc_q),
        .data_in (data_s),
        .poly    (POLY),
        .crc_out (crc_next_s)
    );

    // Finalise the updated CRC and compare it against this cycle's expected value.
    always_comb begin
        fin_s = {CRC_W{1'b0}};
        for (int i = 0; i < CRC_W; i++) begin
            if (REF_OUT) begin
                fin_s[i] = crc_next_s[CRC_W - 1 - i];
            end else begin
                fin_s[i] = crc_next_s[i];
            end
        end
        fin_s   = fin_s ^ XOR_OUT;
        crc_d   = crc_next_s;
        valid_d = (fin_s == crc_received);
    end

    // Running CRC and match flag; reset discards any partial stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q   <= INIT;
            valid_q <= 1'b0;
        end else begin
            crc_q   <= crc_d;
            valid_q <= valid_d;
        end
    end

    assign crc_valid = valid_q;

endmodule

// File: tb/tb_frame_receiver.sv
// Directed and reference-model bench for frame_receiver with a queue scoreboard.
module tb_frame_receiver;

    logic       clk;
    logic       reset;
    logic [7:0] frame_data;
    logic [7:0] crc_received;
    logic       crc_valid;

    int         n_assert;
    int         n_fail;
    logic [7:0] model_crc;
    logic       exp_q[$];

    frame_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .frame_data   (frame_data),
        .crc_received (crc_received),
        .crc_valid    (crc_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CRC-8/ATM: xor byte into register, then eight shift/reduce steps.
    function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            if (r[7]) r = (r << 1) ^ 8'h07;
            else      r = r << 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive one byte, score the flag and running CRC after the edge.
    task automatic send(input string tag, input logic [7:0] d, input logic [7:0] r);
        logic [7:0] nxt;
        logic       e;
        frame_data   = d;
        crc_received = r;
        nxt = ref_crc(model_crc, d);
        exp_q.push_back(nxt == r);
        model_crc = nxt;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_valid"}, {7'd0, crc_valid}, {7'd0, e});
        chk({tag, "_crc"}, dut.crc_q, model_crc);
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks the asynchronous clear before any edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        model_crc = 8'h00;
        #2;
        chk({tag, "_async_valid"}, {7'd0, crc_valid}, 8'h00);
        chk({tag, "_async_crc"}, dut.crc_q, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] r;
        n_assert     = 0;
        n_fail       = 0;
        model_crc    = 8'h00;
        reset        = 1'b1;
        frame_data   = 8'h00;
        crc_received = 8'h00;
        #1;
        reset = 1'b0;
        #1;
        chk("por_valid", {7'd0, crc_valid}, 8'h00);
        chk("por_crc", dut.crc_q, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        send("good0", 8'h01, 8'h07);
        send("good1", 8'h02, 8'h1B);
        send("good2", 8'h10, 8'h31);

        do_reset("rst_a");
        send("bad0", 8'h01, 8'h01);
        send("bad1", 8'h02, 8'h03);
        send("bad2", 8'h10, 8'h11);

        do_reset("rst_b");
        send("mix0", 8'h01, 8'h07);
        send("mix1", 8'h02, 8'h00);
        send("mix2", 8'h10, 8'h31);

        do_reset("rst_c");
        send("pre0", 8'h01, 8'h07);
        send("pre1", 8'h02, 8'h1B);
        do_reset("rst_mid");
        send("restart", 8'h01, 8'h07);

        do_reset("rst_rand");
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            r = ref_crc(model_crc, b);
            if (i == 100) r = r ^ (8'h01 << $urandom_range(0, 7));
            send($sformatf("rand%0d", i), b, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
